// File: rtl/str_acq_ctl_if.sv
// Stream bundle between the ADC source, the acquisition sequencer and the capture buffer.
// slave = sequencer side, master = source/sink (environment) side.
interface str_acq_ctl_if #(parameter int DW = 16);
  logic [DW-1:0] sti_tdata;
  logic          sti_tvalid;
  logic          sti_tready;
  logic [DW-1:0] sto_tdata;
  logic          sto_tvalid;
  logic          sto_tlast;
  logic          sto_tready;

  modport slave (
    input  sti_tdata, sti_tvalid, sto_tready,
    output sti_tready, sto_tdata, sto_tvalid, sto_tlast
  );
  modport master (
    output sti_tdata, sti_tvalid, sto_tready,
    input  sti_tready, sto_tdata, sto_tvalid, sto_tlast
  );
endinterface

// File: rtl/str_acq_ctl.sv
// Acquisition sequencer: pre-trigger fill, trigger wait, post-trigger count with TLAST.
// Optional STR_ACQ_CTL_TRG_LATCH_EN: remember a trigger seen during the pre-trigger fill.
module str_acq_ctl #(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ctl_start,
  input  logic          ctl_stop,
  input  logic          trg,
  input  logic [CW-1:0] cfg_pre,
  input  logic [CW-1:0] cfg_pst,
  str_acq_ctl_if.slave  st,
  output logic          buf_rst,
  output logic [1:0]    sts_state,
  output logic          sts_done,
  output logic [AW-1:0] sts_ptr,
  output logic [AW-1:0] sts_trg_ptr,
  output logic          irq
);
  typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, ARM = 2'd2, POST = 2'd3} state_t;

  state_t        state;
  logic          run, xfer, tlast, trg_hit;
  logic [CW-1:0] pre_cnt, pst_cnt, pre_nxt;
  logic [AW-1:0] ptr_nxt, trg_pos;

  assign run           = (state != IDLE);
  assign st.sto_tdata  = st.sti_tdata;
  assign st.sto_tvalid = st.sti_tvalid & run;
  assign st.sti_tready = run ? st.sto_tready : 1'b1;
  assign xfer          = st.sto_tvalid & st.sto_tready;
  // Depends only on registered state, so it cannot change during a stall
  assign tlast         = (state == POST) && (pst_cnt == cfg_pst - CW'(1));
  assign st.sto_tlast  = tlast;
  assign pre_nxt       = pre_cnt + CW'(xfer);
  assign ptr_nxt       = sts_ptr + AW'(xfer);
  assign sts_state     = state;

`ifdef STR_ACQ_CTL_TRG_LATCH_EN
  logic trg_lat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         trg_lat <= 1'b0;
    else if (ctl_stop || ctl_start)  trg_lat <= 1'b0;
    else if (state == PRE && trg)    trg_lat <= 1'b1;
    else if (state == ARM)           trg_lat <= 1'b0;
  end

  // A remembered trigger fires on the first ARM cycle, at the ARM-entry pointer
  assign trg_hit = trg | trg_lat;
  assign trg_pos = trg_lat ? sts_ptr : ptr_nxt;
`else
  assign trg_hit = trg;
  assign trg_pos = ptr_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pre_cnt     <= '0;
      pst_cnt     <= '0;
      sts_ptr     <= '0;
      sts_trg_ptr <= '0;
      sts_done    <= 1'b0;
      buf_rst     <= 1'b0;
      irq         <= 1'b0;
    end else begin
      buf_rst <= 1'b0;
      irq     <= 1'b0;
      if (ctl_stop) begin
        state <= IDLE;
      end else if (ctl_start) begin
        state       <= PRE;
        pre_cnt     <= '0;
        pst_cnt     <= '0;
        sts_ptr     <= '0;
        sts_trg_ptr <= '0;
        sts_done    <= 1'b0;
        buf_rst     <= 1'b1;
      end else begin
        if (run) sts_ptr <= ptr_nxt;
        case (state)
          PRE: begin
            pre_cnt <= pre_nxt;
            // First term covers cfg_pre == 0
            if (pre_cnt == cfg_pre || pre_nxt == cfg_pre) state <= ARM;
          end
          ARM: begin
            if (trg_hit) begin
              sts_trg_ptr <= trg_pos;
              pst_cnt     <= '0;
              if (cfg_pst == '0) begin
                state    <= IDLE;
                sts_done <= 1'b1;
                irq      <= 1'b1;
              end else begin
                state <= POST;
              end
            end
          end
          POST: begin
            if (xfer) begin
              pst_cnt <= pst_cnt + CW'(1);
              if (tlast) begin
                state    <= IDLE;
                sts_done <= 1'b1;
                irq      <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_str_acq_ctl.sv
// Directed bench for str_acq_ctl; a second AW=4 instance mirrors the stimulus to check pointer wrap.
module tb_str_acq_ctl;
  logic        clk = 1'b0;
  logic        rst, ctl_start, ctl_stop, trg;
  logic [15:0] cfg_pre, cfg_pst;
  logic        buf_rst, sts_done, irq;
  logic [1:0]  sts_state;
  logic [13:0] sts_ptr, sts_trg_ptr;
  logic        buf_rst4, done4, irq4;
  logic [1:0]  state4;
  logic [3:0]  ptr4, tptr4;
  int          n_cmp = 0;
  int          n_err = 0;

  str_acq_ctl_if #(.DW(16)) bus ();
  str_acq_ctl_if #(.DW(16)) bus4 ();

  assign bus4.sti_tdata  = bus.sti_tdata;
  assign bus4.sti_tvalid = bus.sti_tvalid;
  assign bus4.sto_tready = bus.sto_tready;

  str_acq_ctl #(.DW(16), .CW(16), .AW(14)) dut (
    .clk(clk), .rst(rst), .ctl_start(ctl_start), .ctl_stop(ctl_stop), .trg(trg),
    .cfg_pre(cfg_pre), .cfg_pst(cfg_pst), .st(bus.slave), .buf_rst(buf_rst),
    .sts_state(sts_state), .sts_done(sts_done), .sts_ptr(sts_ptr),
    .sts_trg_ptr(sts_trg_ptr), .irq(irq)
  );

  str_acq_ctl #(.DW(16), .CW(16), .AW(4)) dut4 (
    .clk(clk), .rst(rst), .ctl_start(ctl_start), .ctl_stop(ctl_stop), .trg(trg),
    .cfg_pre(cfg_pre), .cfg_pst(cfg_pst), .st(bus4.slave), .buf_rst(buf_rst4),
    .sts_state(state4), .sts_done(done4), .sts_ptr(ptr4),
    .sts_trg_ptr(tptr4), .irq(irq4)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    ctl_start = 1'b1;
    tick();
    ctl_start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ctl_start = 0; ctl_stop = 0; trg = 0; cfg_pre = 0; cfg_pst = 0;
    bus.sti_tdata = 16'h1234; bus.sti_tvalid = 1'b1; bus.sto_tready = 1'b0;
    repeat (2) tick();
    n_cmp++; if (sts_state !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d exp 0", sts_state); end
    n_cmp++; if (sts_done !== 1'b0 || irq !== 1'b0 || buf_rst !== 1'b0) begin n_err++; $display("FAIL rst_flags got done=%b irq=%b buf_rst=%b exp 000", sts_done, irq, buf_rst); end
    n_cmp++; if (sts_ptr !== 14'd0 || sts_trg_ptr !== 14'd0) begin n_err++; $display("FAIL rst_ptrs got %0d/%0d exp 0/0", sts_ptr, sts_trg_ptr); end
    n_cmp++; if (bus.sti_tready !== 1'b1 || bus.sto_tvalid !== 1'b0 || bus.sto_tlast !== 1'b0) begin n_err++; $display("FAIL rst_stream got rdy=%b vld=%b last=%b exp 100", bus.sti_tready, bus.sto_tvalid, bus.sto_tlast); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_capture;
    int nx, ntl, lastpos;
    cfg_pre = 4; cfg_pst = 3; bus.sti_tvalid = 1; bus.sto_tready = 1; bus.sti_tdata = 16'hA5A5;
    do_start();
    n_cmp++; if (buf_rst !== 1'b1 || sts_state !== 2'd1) begin n_err++; $display("FAIL cap_start got buf_rst=%b state=%0d exp 1/1", buf_rst, sts_state); end
    n_cmp++; if (bus.sto_tdata !== 16'hA5A5) begin n_err++; $display("FAIL cap_tdata got %h exp a5a5", bus.sto_tdata); end
    repeat (9) tick();
    n_cmp++; if (sts_state !== 2'd2 || sts_ptr !== 14'd9) begin n_err++; $display("FAIL cap_arm got state=%0d ptr=%0d exp 2/9", sts_state, sts_ptr); end
    trg = 1; tick(); trg = 0;
    n_cmp++; if (sts_state !== 2'd3 || sts_trg_ptr !== 14'd10) begin n_err++; $display("FAIL cap_trg got state=%0d trg_ptr=%0d exp 3/10", sts_state, sts_trg_ptr); end
    nx = 0; ntl = 0; lastpos = 0;
    for (int i = 0; i < 10 && sts_state == 2'd3; i++) begin
      if (bus.sto_tvalid && bus.sto_tready) begin
        nx++;
        if (bus.sto_tlast) begin ntl++; lastpos = nx; end
      end
      tick();
    end
    n_cmp++; if (nx !== 3 || ntl !== 1 || lastpos !== 3) begin n_err++; $display("FAIL cap_post got nx=%0d ntl=%0d lastpos=%0d exp 3/1/3", nx, ntl, lastpos); end
    n_cmp++; if (sts_state !== 2'd0 || irq !== 1'b1 || sts_done !== 1'b1 || sts_ptr !== 14'd13) begin n_err++; $display("FAIL cap_done got state=%0d irq=%b done=%b ptr=%0d exp 0/1/1/13", sts_state, irq, sts_done, sts_ptr); end
    tick();
    n_cmp++; if (irq !== 1'b0 || sts_done !== 1'b1) begin n_err++; $display("FAIL cap_irq_pulse got irq=%b done=%b exp 0/1", irq, sts_done); end
  endtask

  task automatic test_trg_in_pre;
    cfg_pre = 4; cfg_pst = 3; bus.sti_tvalid = 1; bus.sto_tready = 1;
    do_start();
    tick();
    trg = 1; tick(); trg = 0;
    tick(); tick();
    n_cmp++; if (sts_state !== 2'd2 || sts_ptr !== 14'd4) begin n_err++; $display("FAIL pre_trg_arm got state=%0d ptr=%0d exp 2/4", sts_state, sts_ptr); end
    tick();
`ifdef STR_ACQ_CTL_TRG_LATCH_EN
    n_cmp++; if (sts_state !== 2'd3 || sts_trg_ptr !== 14'd4) begin n_err++; $display("FAIL pre_trg_latch got state=%0d trg_ptr=%0d exp 3/4", sts_state, sts_trg_ptr); end
`else
    n_cmp++; if (sts_state !== 2'd2 || sts_trg_ptr !== 14'd0) begin n_err++; $display("FAIL pre_trg_ignore got state=%0d trg_ptr=%0d exp 2/0", sts_state, sts_trg_ptr); end
    trg = 1; tick(); trg = 0;
    n_cmp++; if (sts_state !== 2'd3 || sts_trg_ptr !== 14'd6) begin n_err++; $display("FAIL pre_trg_late got state=%0d trg_ptr=%0d exp 3/6", sts_state, sts_trg_ptr); end
`endif
    for (int i = 0; i < 10 && sts_state != 2'd0; i++) tick();
    n_cmp++; if (sts_state !== 2'd0 || sts_done !== 1'b1) begin n_err++; $display("FAIL pre_trg_done got state=%0d done=%b exp 0/1", sts_state, sts_done); end
  endtask

  task automatic test_backpressure;
    int nx, ntl, stall_tl;
    logic prev_tl, prev_x;
    cfg_pre = 2; cfg_pst = 5; bus.sti_tvalid = 1; bus.sto_tready = 1;
    do_start();
    tick(); tick();
    n_cmp++; if (sts_state !== 2'd2) begin n_err++; $display("FAIL bp_arm got state=%0d exp 2", sts_state); end
    trg = 1; tick(); trg = 0;
    nx = 0; ntl = 0; stall_tl = 0; prev_tl = 0; prev_x = 0;
    for (int i = 0; i < 30 && sts_state == 2'd3; i++) begin
      bus.sto_tready = i[0];
      #1;
      if (prev_tl && !prev_x) begin
        n_cmp++; if (bus.sto_tlast !== 1'b1) begin n_err++; $display("FAIL bp_tlast_hold got %b exp 1 at i=%0d", bus.sto_tlast, i); end
      end
      if (bus.sto_tvalid && bus.sto_tready) begin nx++; if (bus.sto_tlast) ntl++; end
      if (bus.sto_tlast && !bus.sto_tready) stall_tl++;
      prev_tl = bus.sto_tlast;
      prev_x  = bus.sto_tvalid & bus.sto_tready;
      tick();
    end
    bus.sto_tready = 1;
    n_cmp++; if (nx !== 5 || ntl !== 1 || stall_tl !== 1) begin n_err++; $display("FAIL bp_count got nx=%0d ntl=%0d stalls=%0d exp 5/1/1", nx, ntl, stall_tl); end
    n_cmp++; if (sts_state !== 2'd0 || irq !== 1'b1) begin n_err++; $display("FAIL bp_done got state=%0d irq=%b exp 0/1", sts_state, irq); end
  endtask

  task automatic test_stop;
    cfg_pre = 1; cfg_pst = 3; bus.sti_tvalid = 1; bus.sto_tready = 1;
    do_start(); tick();
    n_cmp++; if (sts_state !== 2'd2) begin n_err++; $display("FAIL stop_arm got state=%0d exp 2", sts_state); end
    ctl_stop = 1; tick(); ctl_stop = 0;
    bus.sto_tready = 0; #1;
    n_cmp++; if (sts_state !== 2'd0 || sts_done !== 1'b0 || irq !== 1'b0 || bus.sti_tready !== 1'b1) begin n_err++; $display("FAIL stop_idle got state=%0d done=%b irq=%b rdy=%b exp 0/0/0/1", sts_state, sts_done, irq, bus.sti_tready); end
    bus.sto_tready = 1;
    tick();
    n_cmp++; if (irq !== 1'b0 || bus.sto_tlast !== 1'b0) begin n_err++; $display("FAIL stop_noirq got irq=%b last=%b exp 0/0", irq, bus.sto_tlast); end
    do_start(); tick();
    ctl_start = 1; ctl_stop = 1; tick(); ctl_start = 0; ctl_stop = 0;
    n_cmp++; if (sts_state !== 2'd0 || buf_rst !== 1'b0 || sts_done !== 1'b0 || irq !== 1'b0) begin n_err++; $display("FAIL startstop got state=%0d buf_rst=%b done=%b irq=%b exp 0/0/0/0", sts_state, buf_rst, sts_done, irq); end
    do_start(); tick(); tick();
    n_cmp++; if (sts_ptr !== 14'd2) begin n_err++; $display("FAIL restart_pre got ptr=%0d exp 2", sts_ptr); end
    do_start();
    n_cmp++; if (sts_state !== 2'd1 || sts_ptr !== 14'd0 || buf_rst !== 1'b1) begin n_err++; $display("FAIL restart got state=%0d ptr=%0d buf_rst=%b exp 1/0/1", sts_state, sts_ptr, buf_rst); end
    ctl_stop = 1; tick(); ctl_stop = 0;
  endtask

  task automatic test_pst_zero_wrap;
    cfg_pre = 0; cfg_pst = 0; bus.sti_tvalid = 0; bus.sto_tready = 1;
    do_start(); tick();
    n_cmp++; if (sts_state !== 2'd2) begin n_err++; $display("FAIL pz_arm got state=%0d exp 2", sts_state); end
    trg = 1; #1;
    n_cmp++; if (bus.sto_tlast !== 1'b0) begin n_err++; $display("FAIL pz_tlast got %b exp 0", bus.sto_tlast); end
    tick(); trg = 0;
    n_cmp++; if (sts_state !== 2'd0 || irq !== 1'b1 || sts_done !== 1'b1) begin n_err++; $display("FAIL pz_done got state=%0d irq=%b done=%b exp 0/1/1", sts_state, irq, sts_done); end
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL pz_irq_pulse got %b exp 0", irq); end
    cfg_pst = 3;
    do_start(); tick();
    bus.sti_tvalid = 1;
    repeat (20) tick();
    bus.sti_tvalid = 0;
    n_cmp++; if (sts_ptr !== 14'd20 || ptr4 !== 4'd4 || state4 !== 2'd2) begin n_err++; $display("FAIL wrap got ptr=%0d ptr4=%0d state4=%0d exp 20/4/2", sts_ptr, ptr4, state4); end
    trg = 1; tick(); trg = 0;
    n_cmp++; if (sts_trg_ptr !== 14'd20 || tptr4 !== 4'd4) begin n_err++; $display("FAIL wrap_trg got trg_ptr=%0d trg_ptr4=%0d exp 20/4", sts_trg_ptr, tptr4); end
    ctl_stop = 1; tick(); ctl_stop = 0;
  endtask

  task automatic test_reset_mid_post;
    cfg_pre = 4; cfg_pst = 4; bus.sti_tvalid = 1; bus.sto_tready = 1;
    do_start();
    repeat (4) tick();
    trg = 1; tick(); trg = 0;
    tick(); tick();
    n_cmp++; if (sts_state !== 2'd3 || bus.sto_tlast !== 1'b0) begin n_err++; $display("FAIL rmp_post got state=%0d last=%b exp 3/0", sts_state, bus.sto_tlast); end
    bus.sto_tready = 0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (sts_state !== 2'd0 || sts_ptr !== 14'd0 || sts_trg_ptr !== 14'd0) begin n_err++; $display("FAIL rmp_regs got state=%0d ptr=%0d trg_ptr=%0d exp 0/0/0", sts_state, sts_ptr, sts_trg_ptr); end
    n_cmp++; if (bus.sti_tready !== 1'b1 || bus.sto_tvalid !== 1'b0 || bus.sto_tlast !== 1'b0 || irq !== 1'b0 || sts_done !== 1'b0 || buf_rst !== 1'b0) begin n_err++; $display("FAIL rmp_outs got rdy=%b vld=%b last=%b irq=%b done=%b buf_rst=%b exp 100000", bus.sti_tready, bus.sto_tvalid, bus.sto_tlast, irq, sts_done, buf_rst); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_trg_in_pre();
    test_backpressure();
    test_stop();
    test_pst_zero_wrap();
    test_reset_mid_post();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/str_acq_ctl.md
# str_acq_ctl

Acquisition sequencer between an ADC sample stream and the stream-to-RAM capture buffer. It gates an AXI4-stream through to the buffer, counts a pre-trigger fill, waits for a trigger and counts post-trigger samples. It terminates the capture with TLAST and reports the trigger write position and completion. It is configured and started from the system bus register block.

## Interface
- DW, 16, sample width in bits (TDATA width).
- CW, 16, pre/post-trigger counter width.
- AW, 14, buffer sample-address width (write pointer modulo 2**AW).
- clk  in  1  system clock; all logic single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- ctl_start  in  1  single-cycle pulse: (re)arm acquisition.
- ctl_stop  in  1  single-cycle pulse: abort acquisition.
- trg  in  1  trigger event pulse.
- cfg_pre  in  CW  pre-trigger transfers to accept before trigger is honoured.
- cfg_pst  in  CW  post-trigger transfers including the TLAST one.
- sti_tdata  in  DW  input stream data.
- sti_tvalid  in  1  input stream valid.
- sti_tready  out  1  input stream ready.
- sto_tdata  out  DW  output stream data to buffer.
- sto_tvalid  out  1  output stream valid.
- sto_tlast  out  1  marks final capture sample.
- sto_tready  in  1  buffer ready.
- buf_rst  out  1  one-cycle buffer pointer clear.
- sts_state  out  2  0 IDLE, 1 PRE, 2 ARM, 3 POST.
- sts_done  out  1  capture completed, sticky until next start.
- sts_ptr  out  AW  current write pointer (transfers since start, wraps).
- sts_trg_ptr  out  AW  write pointer latched at trigger.
- irq  out  1  one-cycle pulse on completion.

## Operation
- run = (state != IDLE). sto_tdata = sti_tdata; sto_tvalid = sti_tvalid & run; sti_tready = run ? sto_tready : 1 (stream drained/discarded in IDLE). xfer = sto_tvalid & sto_tready.
- IDLE: on ctl_start -> PRE; counters, sts_ptr, sts_trg_ptr cleared; sts_done cleared; buf_rst pulses.
- PRE: pre_cnt += xfer; when pre_cnt reaches cfg_pre (including by this cycle's xfer) -> ARM. cfg_pre=0 -> ARM on the cycle after start. Triggers in PRE ignored (see Configuration).
- ARM: on trg -> POST, sts_trg_ptr <= sts_ptr + xfer (the xfer in the trigger cycle belongs to ARM). cfg_pst=0: trigger goes directly to IDLE with sts_done and irq, no TLAST.
- POST: pst_cnt += xfer; sto_tlast = (state==POST) & (pst_cnt == cfg_pst-1); xfer with tlast -> IDLE, sts_done<=1, irq pulse.
- sts_ptr += xfer in every non-IDLE state; wraps modulo 2**AW without flag.
- Priorities: ctl_stop > ctl_start > trg/count transitions. ctl_stop in any state -> IDLE, sts_done stays 0, no irq, no TLAST. ctl_start while running restarts exactly as from IDLE.
- cfg_pre/cfg_pst are sampled live; software must not change them while running.
- Counters are CW bits, unsigned; comparisons are equality only.

## Timing
- Reset values: state IDLE, sts_done 0, irq 0, buf_rst 0, sts_ptr 0, sts_trg_ptr 0, internal counters 0; sti_tready 1, sto_tvalid 0, sto_tlast 0.
- Stream path is combinational (zero latency); state, counters and status are registered.
- ctl_start at cycle n: buf_rst high and state PRE at n+1; the first transfer can be accepted at n+1.
- Completing xfer at cycle n: state IDLE, sts_done 1 and irq 1 at n+1; irq low at n+2.
- TLAST is stable while sto_tvalid is held without sto_tready (AXI rules preserved).

## Configuration
- STR_ACQ_CTL_TRG_LATCH_EN defined: a trg seen in PRE is latched. On entering ARM, the block goes to POST on the next cycle and sts_trg_ptr holds the pointer at ARM entry. The latch clears on start, stop and reset.
- Undefined: trg in PRE is discarded; only triggers in ARM count.

## Test plan
- Reset mid-POST (cfg_pre=4, cfg_pst=4, two post samples accepted, rst pulse) -> all outputs at reset values immediately; sti_tready=1.
- cfg_pre=4, cfg_pst=3, continuous valid/ready, trg 10 cycles after start -> exactly 3 post transfers, TLAST on the 3rd, irq one cycle later, sts_done=1.
- Same setup, trg in PRE at cycle 2 -> macro off: waits in ARM, sts_trg_ptr=0 until a later trg. Macro on: POST one cycle after ARM entry, sts_trg_ptr=4.
- Backpressure: sto_tready toggling 50 %, cfg_pst=5 -> TLAST held steady through stalls; 5 post transfers counted.
- ctl_stop during ARM; ctl_start and ctl_stop in the same cycle -> IDLE, no irq, sts_done=0 in both cases.
- cfg_pst=0 with trg in ARM -> IDLE next cycle, irq pulse, no TLAST; AW=4 with 20 ARM transfers -> sts_ptr wraps to 4.
